// File: rtl/if_stage.sv
// Instruction-fetch stage: word-addressed PC, loader-written instruction memory
// and the IF/ID pipeline register feeding the decode stage and jump unit.
module if_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_pcjump,
  input  logic                  i_load_we,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic                  o_valid,
  output logic                  o_halt
);

  localparam int             DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [5:0]     HALT_OP = 6'b111111;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [DATA_WIDTH-1:0] id_instr_q, id_instr_d;
  logic                  id_valid_q, id_valid_d;
  logic                  halt_q, halt_d;

  logic [DATA_WIDTH-1:0] fetch_word;
  logic                  adv;

  // Upper PC bits are ignored, so fetch wraps modulo the memory depth.
  assign fetch_word = mem[pc_q[ADDR_WIDTH-1:0]];
  assign adv        = i_enable & ~i_stall & ~halt_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    halt_d     = halt_q;

    if (halt_q) begin
      // Once halted, IF/ID is kept as a bubble so the downstream pipe drains.
      id_pc_d    = '0;
      id_instr_d = '0;
      id_valid_d = 1'b0;
    end else if (adv) begin
      if (i_jump) begin
        // Redirect flushes the wrong-path fetch; no delay slot, no halt detection.
        pc_d       = i_pcjump;
        id_pc_d    = '0;
        id_instr_d = '0;
        id_valid_d = 1'b0;
      end else begin
        pc_d       = pc_q + DATA_WIDTH'(1);
        id_pc_d    = pc_q;
        id_instr_d = fetch_word;
        id_valid_d = 1'b1;
        halt_d     = (fetch_word[DATA_WIDTH-1 -: 6] == HALT_OP);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    // NOTE: reset is synchronous and state uses non-blocking assignments only.
    if (!i_reset) begin
      pc_q       <= '0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_valid_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      halt_q     <= halt_d;
    end
  end

  // NOTE: the memory array is deliberately not reset; the loader owns its contents.
  // A same-edge write to the fetched address is seen by the fetch one cycle later.
  always_ff @(posedge i_clock) begin
    if (i_load_we) begin
      mem[i_load_addr] <= i_load_data;
    end
  end

  assign o_pc          = id_pc_q;
  assign o_instruccion = id_instr_q;
  assign o_valid       = id_valid_q;
  assign o_halt        = halt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random traffic, all checked
// against a cycle-level reference model of the fetch rules.
module tb_if_stage;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset, enable, stall, jump, load_we;
  logic [DW-1:0] pcjump, load_data;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] o_pc, o_instruccion;
  logic          o_valid, o_halt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what IF/ID and PC should hold after each edge.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_pc     = '0;
  logic [DW-1:0] e_pc     = '0;
  logic [DW-1:0] e_instr  = '0;
  logic          e_valid  = 1'b0;
  logic          e_halt   = 1'b0;

  always #5 clk = ~clk;

  if_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clock       (clk),
    .i_reset       (reset),
    .i_enable      (enable),
    .i_stall       (stall),
    .i_jump        (jump),
    .i_pcjump      (pcjump),
    .i_load_we     (load_we),
    .i_load_addr   (load_addr),
    .i_load_data   (load_data),
    .o_pc          (o_pc),
    .o_instruccion (o_instruccion),
    .o_valid       (o_valid),
    .o_halt        (o_halt)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the architectural rules, using the inputs seen at the edge.
  task automatic model_step();
    logic [DW-1:0] word;
    word = m_mem[m_pc[AW-1:0]];
    if (!reset) begin
      m_pc = '0; e_pc = '0; e_instr = '0; e_valid = 1'b0; e_halt = 1'b0;
    end else if (e_halt) begin
      e_pc = '0; e_instr = '0; e_valid = 1'b0;
    end else if (enable && !stall && jump) begin
      m_pc = pcjump; e_pc = '0; e_instr = '0; e_valid = 1'b0;
    end else if (enable && !stall) begin
      e_pc = m_pc; e_instr = word; e_valid = 1'b1;
      e_halt = (word[31:26] == 6'h3F);
      m_pc = m_pc + 1;
    end
    if (load_we) m_mem[load_addr] = load_data;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, " o_pc"}, o_pc, e_pc);
    check({tag, " o_instruccion"}, o_instruccion, e_instr);
    check({tag, " o_valid"}, {31'd0, o_valid}, {31'd0, e_valid});
    check({tag, " o_halt"}, {31'd0, o_halt}, {31'd0, e_halt});
  endtask

  function automatic logic [DW-1:0] rand_nonhalt();
    logic [DW-1:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    return w;
  endfunction

  task automatic load(input int addr, input logic [DW-1:0] data);
    load_we = 1'b1; load_addr = AW'(addr); load_data = data;
    cycle("load");
    load_we = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] new_word;
    reset = 1'b0; enable = 1'b0; stall = 1'b0; jump = 1'b0; pcjump = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0;

    // Preload the whole memory while in reset; outputs must stay at reset values.
    for (int i = 0; i < DEPTH; i++) load(i, rand_nonhalt());
    load(0, 32'h2001_0005);
    load(1, 32'h2002_0007);
    load(2, 32'h0022_1820);
    load(3, 32'hFC00_0000);
    load(9, 32'hFC00_0000);
    load(8'h30, 32'hFC00_0000);
    check("reset o_pc", o_pc, 32'd0);
    check("reset o_valid", {31'd0, o_valid}, 32'd0);

    // Sequential fetch up to the HALT word.
    reset = 1'b1; enable = 1'b1;
    cycle("seq0");
    check("seq0 word", o_instruccion, 32'h2001_0005);
    cycle("seq1");
    check("seq1 pc", o_pc, 32'd1);
    cycle("seq2");
    check("seq2 word", o_instruccion, 32'h0022_1820);
    cycle("seq3");
    check("halt pc", o_pc, 32'd3);
    check("halt flag", {31'd0, o_halt}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle("halted");
      check("halted valid", {31'd0, o_valid}, 32'd0);
    end

    // Jump flush at PC=5.
    enable = 1'b0;
    load(3, 32'h0000_0000);
    reset = 1'b0;
    cycle("rstB");
    reset = 1'b1; enable = 1'b1;
    for (int i = 0; i < 5; i++) cycle("runB");
    jump = 1'b1; pcjump = 32'h20;
    cycle("jumpB");
    check("flush valid", {31'd0, o_valid}, 32'd0);
    check("flush word", o_instruccion, 32'd0);
    jump = 1'b0;
    cycle("tgtB");
    check("target pc", o_pc, 32'h20);
    check("target word", o_instruccion, m_mem[8'h20]);

    // Stall with a jump request held for three cycles at o_pc=7.
    reset = 1'b0;
    cycle("rstC");
    reset = 1'b1;
    for (int i = 0; i < 8; i++) cycle("runC");
    stall = 1'b1; jump = 1'b1; pcjump = 32'h55;
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      check("stall pc", o_pc, 32'd7);
      check("stall word", o_instruccion, m_mem[7]);
    end
    stall = 1'b0; jump = 1'b0;
    cycle("release");
    check("release pc", o_pc, 32'd8);

    // Jump while the HALT word at 9 is being fetched: jump wins.
    jump = 1'b1; pcjump = 32'h10;
    cycle("jump_halt");
    check("no halt", {31'd0, o_halt}, 32'd0);
    jump = 1'b0;
    cycle("resume");
    check("resume pc", o_pc, 32'h10);

    // Fetch index wrap, then enable low holds everything.
    jump = 1'b1; pcjump = 32'hFF;
    cycle("to_ff");
    jump = 1'b0;
    cycle("pc_ff");
    cycle("pc_100");
    check("wrap pc", o_pc, 32'h100);
    check("wrap word", o_instruccion, m_mem[0]);
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle("disabled");
      check("disabled pc", o_pc, 32'h100);
    end

    // Write to the address being fetched: old word now, new word on refetch.
    enable = 1'b1;
    new_word = 32'h1234_5678;
    load_we = 1'b1; load_addr = 8'h01; load_data = new_word;
    cycle("wr_fetch");
    load_we = 1'b0;
    jump = 1'b1; pcjump = 32'h1;
    cycle("refetch_j");
    jump = 1'b0;
    cycle("refetch");
    check("refetch word", o_instruccion, new_word);

    // Halt, then reset while halted with a load on the same edge.
    jump = 1'b1; pcjump = 32'h30;
    cycle("to_halt");
    jump = 1'b0;
    cycle("halt30");
    check("halt30 flag", {31'd0, o_halt}, 32'd1);
    cycle("halt30b");
    reset = 1'b0; load_we = 1'b1; load_addr = 8'h40; load_data = 32'hCAFE_0040;
    cycle("rst_halt");
    check("rst halt flag", {31'd0, o_halt}, 32'd0);
    check("rst pc", o_pc, 32'd0);
    reset = 1'b1; load_we = 1'b0; jump = 1'b1; pcjump = 32'h40;
    cycle("to_40");
    jump = 1'b0;
    cycle("fetch40");
    check("reset-load word", o_instruccion, 32'hCAFE_0040);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 49) != 0);
      enable  = ($urandom_range(0, 3) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      jump    = ($urandom_range(0, 9) == 0);
      pcjump  = ($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'($urandom_range(0, 511));
      load_we = ($urandom_range(0, 15) == 0);
      load_addr = AW'($urandom);
      load_data = ($urandom_range(0, 15) == 0) ? 32'hFC00_0000 : rand_nonhalt();
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
